// File: rtl/cdb_arbiter_multi.sv
// cdb_arbiter_multi: common-data-bus front end. Per-source result FIFOs feed
// NUM_BUS registered broadcast lanes, granted round-robin from rr_ptr.
// ROB flushes mark matching entries as killed; killed heads drain silently.
// Optional feature macro: CDB_BYPASS_EN. When it is defined, a result arriving
// at an empty FIFO can be granted in its arrival cycle (1-cycle latency).
module cdb_arbiter_multi #(
  parameter int NUM_SRC   = 5,
  parameter int NUM_BUS   = 2,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32,
  parameter int SRC_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]           src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]          src_data,
  input  logic                               flush,
  input  logic [(2**TAG_W)-1:0]              flush_mask,
  output logic [NUM_BUS-1:0]                 bus_valid,
  output logic [NUM_BUS*TAG_W-1:0]           bus_tag,
  output logic [NUM_BUS*DATA_W-1:0]          bus_data,
  output logic [NUM_BUS*$clog2(NUM_SRC)-1:0] bus_src
);

  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int NSUM_W = SRC_W + 1;
  localparam int PTR_W  = $clog2(SRC_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // FIFO storage and control state
  logic [TAG_W-1:0]     fifo_tag_q  [NUM_SRC][SRC_DEPTH];
  logic [TAG_W-1:0]     fifo_tag_d  [NUM_SRC][SRC_DEPTH];
  logic [DATA_W-1:0]    fifo_data_q [NUM_SRC][SRC_DEPTH];
  logic [DATA_W-1:0]    fifo_data_d [NUM_SRC][SRC_DEPTH];
  logic [SRC_DEPTH-1:0] fifo_kill_q [NUM_SRC];
  logic [SRC_DEPTH-1:0] fifo_kill_d [NUM_SRC];
  logic [PTR_W-1:0]     rd_ptr_q    [NUM_SRC];
  logic [PTR_W-1:0]     rd_ptr_d    [NUM_SRC];
  logic [PTR_W-1:0]     wr_ptr_q    [NUM_SRC];
  logic [PTR_W-1:0]     wr_ptr_d    [NUM_SRC];
  logic [CNT_W-1:0]     cnt_q       [NUM_SRC];
  logic [CNT_W-1:0]     cnt_d       [NUM_SRC];
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;

  // Registered bus lanes
  logic [NUM_BUS-1:0]        bus_valid_q, bus_valid_d;
  logic [NUM_BUS*TAG_W-1:0]  bus_tag_q,   bus_tag_d;
  logic [NUM_BUS*DATA_W-1:0] bus_data_q,  bus_data_d;
  logic [NUM_BUS*SRC_W-1:0]  bus_src_q,   bus_src_d;

  // Per-source combinational view
  logic [NUM_SRC-1:0]   full, push, in_kill, stored, head_kill, byp, cand, grant, store, pop;
  logic [TAG_W-1:0]     in_tag    [NUM_SRC];
  logic [DATA_W-1:0]    in_data   [NUM_SRC];
  logic [TAG_W-1:0]     head_tag  [NUM_SRC];
  logic [DATA_W-1:0]    head_data [NUM_SRC];
  logic [SRC_DEPTH-1:0] kill_eff  [NUM_SRC];

  // Head selection: apply this cycle's flush to residents and incoming results, pick candidates
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      in_tag[i]  = src_tag[i*TAG_W +: TAG_W];
      in_data[i] = src_data[i*DATA_W +: DATA_W];
      full[i]    = (cnt_q[i] == CNT_W'(SRC_DEPTH));
      push[i]    = src_valid[i] & ~full[i];
      in_kill[i] = flush & flush_mask[in_tag[i]];
      for (int e = 0; e < SRC_DEPTH; e++) begin
        kill_eff[i][e] = fifo_kill_q[i][e] | (flush & flush_mask[fifo_tag_q[i][e]]);
      end
      stored[i]    = (cnt_q[i] != '0);
      head_kill[i] = stored[i] & kill_eff[i][rd_ptr_q[i]];
      head_tag[i]  = fifo_tag_q[i][rd_ptr_q[i]];
      head_data[i] = fifo_data_q[i][rd_ptr_q[i]];
      byp[i]       = 1'b0;
`ifdef CDB_BYPASS_EN
      byp[i] = ~stored[i] & src_valid[i] & ~in_kill[i];
      if (byp[i]) begin
        head_tag[i]  = in_tag[i];
        head_data[i] = in_data[i];
      end
`endif
      cand[i] = (stored[i] & ~head_kill[i]) | byp[i];
    end
  end

  // Readiness depends only on occupancy, so a pop this cycle does not reopen a full FIFO
  assign src_ready = ~full;

  // Round-robin scan from rr_ptr; grants packed into lanes in scan order
  always_comb begin
    logic [NSUM_W-1:0] sum;
    logic [SRC_W-1:0]  idx;
    int                n;
    grant       = '0;
    n           = 0;
    sum         = '0;
    idx         = '0;
    rr_ptr_d    = rr_ptr_q;
    bus_valid_d = '0;
    bus_tag_d   = bus_tag_q;
    bus_data_d  = bus_data_q;
    bus_src_d   = bus_src_q;
    for (int j = 0; j < NUM_SRC; j++) begin
      sum = NSUM_W'(rr_ptr_q) + NSUM_W'(j);
      if (sum >= NSUM_W'(NUM_SRC)) begin
        sum = sum - NSUM_W'(NUM_SRC);
      end
      idx = sum[SRC_W-1:0];
      if (cand[idx] && (n < NUM_BUS)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NUM_BUS; k++) begin
          if (n == k) begin
            bus_valid_d[k]                  = 1'b1;
            bus_tag_d[k*TAG_W +: TAG_W]     = head_tag[idx];
            bus_data_d[k*DATA_W +: DATA_W]  = head_data[idx];
            bus_src_d[k*SRC_W +: SRC_W]     = idx;
          end
        end
        rr_ptr_d = (sum == NSUM_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
        n++;
      end
    end
  end

  // FIFO next state: store unless bypassed straight onto a lane; pop grants and killed heads
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int e = 0; e < SRC_DEPTH; e++) begin
        fifo_tag_d[i][e]  = fifo_tag_q[i][e];
        fifo_data_d[i][e] = fifo_data_q[i][e];
      end
      fifo_kill_d[i] = kill_eff[i];
      rd_ptr_d[i]    = rd_ptr_q[i];
      wr_ptr_d[i]    = wr_ptr_q[i];
      store[i]       = push[i] & ~(byp[i] & grant[i]);
      pop[i]         = stored[i] & (grant[i] | head_kill[i]);
      if (store[i]) begin
        fifo_tag_d[i][wr_ptr_q[i]]  = in_tag[i];
        fifo_data_d[i][wr_ptr_q[i]] = in_data[i];
        fifo_kill_d[i][wr_ptr_q[i]] = in_kill[i];
        wr_ptr_d[i]                 = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(store[i]) - CNT_W'(pop[i]);
    end
  end

  // Control state and bus lanes, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q    <= '0;
      bus_valid_q <= '0;
      bus_tag_q   <= '0;
      bus_data_q  <= '0;
      bus_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      bus_valid_q <= bus_valid_d;
      bus_tag_q   <= bus_tag_d;
      bus_data_q  <= bus_data_d;
      bus_src_q   <= bus_src_d;
    end
  end

  // Entry payload; occupancy alone decides which slots are live, so no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int e = 0; e < SRC_DEPTH; e++) begin
        fifo_tag_q[i][e]  <= fifo_tag_d[i][e];
        fifo_data_q[i][e] <= fifo_data_d[i][e];
      end
      fifo_kill_q[i] <= fifo_kill_d[i];
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_tag   = bus_tag_q;
  assign bus_data  = bus_data_q;
  assign bus_src   = bus_src_q;

endmodule

// File: tb/tb_cdb_arbiter_multi.sv
// Testbench for cdb_arbiter_multi: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the bus.
module tb_cdb_arbiter_multi;
  localparam int NS = 5, NB = 2, TW = 3, DW = 32, DEPTH = 2, SW = 3;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*TW-1:0]  src_tag;
  logic [NS*DW-1:0]  src_data;
  logic              flush;
  logic [7:0]        flush_mask;
  logic [NB-1:0]     bus_valid;
  logic [NB*TW-1:0]  bus_tag;
  logic [NB*DW-1:0]  bus_data;
  logic [NB*SW-1:0]  bus_src;

  always #5 clk = ~clk;

  cdb_arbiter_multi dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data),
    .flush(flush), .flush_mask(flush_mask),
    .bus_valid(bus_valid), .bus_tag(bus_tag),
    .bus_data(bus_data), .bus_src(bus_src)
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          kill;
  } ent_t;

  ent_t          mq [NS][$];
  int            rr_m = 0;
  int            checks = 0;
  int            errors = 0;
  logic [NB-1:0] exp_bv;
  logic [TW-1:0] exp_tag  [NB];
  logic [DW-1:0] exp_data [NB];
  int            exp_src  [NB];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    rr_m = 0;
  endtask

  // One cycle of the bus behaviour: kill flushed tags, grant up to NB heads
  // starting at rr_m, then retire granted/killed heads and queue new pushes.
  task automatic model_cycle(input logic [NS-1:0] v, input logic [NS*TW-1:0] t,
                             input logic [NS*DW-1:0] d, input logic fl,
                             input logic [7:0] fm, output logic [NS-1:0] rdy);
    logic [NS-1:0] ikill, byp, cand, gnt;
    logic [TW-1:0] tg;
    ent_t          e;
    int            n, s, rr_next;
    for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() < DEPTH);
    if (fl) begin
      for (int i = 0; i < NS; i++) begin
        for (int k = 0; k < mq[i].size(); k++) begin
          e = mq[i][k];
          if (fm[e.tag]) e.kill = 1'b1;
          mq[i][k] = e;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      tg       = t[i*TW +: TW];
      ikill[i] = fl && fm[tg];
      byp[i]   = BYP && (mq[i].size() == 0) && v[i] && !ikill[i];
      cand[i]  = ((mq[i].size() > 0) && !mq[i][0].kill) || byp[i];
    end
    exp_bv  = '0;
    gnt     = '0;
    n       = 0;
    rr_next = rr_m;
    for (int j = 0; j < NS; j++) begin
      s = (rr_m + j) % NS;
      if (cand[s] && n < NB) begin
        gnt[s] = 1'b1;
        exp_bv = exp_bv | (NB'(1) << n);
        if (mq[s].size() > 0) begin
          exp_tag[n]  = mq[s][0].tag;
          exp_data[n] = mq[s][0].data;
        end else begin
          exp_tag[n]  = t[s*TW +: TW];
          exp_data[n] = d[s*DW +: DW];
        end
        exp_src[n] = s;
        rr_next    = (s + 1) % NS;
        n++;
      end
    end
    rr_m = rr_next;
    for (int i = 0; i < NS; i++) begin
      if (mq[i].size() > 0 && (gnt[i] || mq[i][0].kill)) void'(mq[i].pop_front());
      if (v[i] && rdy[i] && !(byp[i] && gnt[i])) begin
        e.tag  = t[i*TW +: TW];
        e.data = d[i*DW +: DW];
        e.kill = ikill[i];
        mq[i].push_back(e);
      end
    end
  endtask

  // Drive one cycle from a negedge, check readiness, then check lanes after the edge
  task automatic step(input logic [NS-1:0] v, input logic [NS*TW-1:0] t,
                      input logic [NS*DW-1:0] d, input logic fl, input logic [7:0] fm);
    logic [NS-1:0] rdy;
    src_valid  = v;
    src_tag    = t;
    src_data   = d;
    flush      = fl;
    flush_mask = fm;
    #1;
    model_cycle(v, t, d, fl, fm, rdy);
    chk("src_ready", 64'(src_ready), 64'(rdy));
    @(posedge clk);
    #1;
    chk("bus_valid", 64'(bus_valid), 64'(exp_bv));
    for (int k = 0; k < NB; k++) begin
      if (exp_bv[k]) begin
        chk("lane_tag", 64'(bus_tag[k*TW +: TW]), 64'(exp_tag[k]));
        chk("lane_data", 64'(bus_data[k*DW +: DW]), 64'(exp_data[k]));
        chk("lane_src", 64'(bus_src[k*SW +: SW]), 64'(exp_src[k]));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step('0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NS-1:0]    rv;
    logic [NS*TW-1:0] rt;
    logic [NS*DW-1:0] rd;
    logic             rf;
    logic [7:0]       rm;

    // Reset with every producer asserting valid: nothing may be accepted
    rst        = 1'b1;
    src_valid  = '1;
    src_tag    = '0;
    src_data   = '0;
    flush      = 1'b0;
    flush_mask = '0;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    src_valid = '0;
    #1;
    chk("t1_ready", 64'(src_ready), 64'h1F);
    chk("t1_bus_valid", 64'(bus_valid), 64'h0);
    model_reset();
    @(negedge clk);

    // Single result from source 0
    step(5'b00001, {12'd0, 3'd3}, {128'd0, 32'hDEAD_BEEF}, 1'b0, '0);
`ifndef CDB_BYPASS_EN
    idle();
`endif
    chk("t2_valid", 64'(bus_valid), 64'h1);
    chk("t2_tag", 64'(bus_tag[2:0]), 64'd3);
    chk("t2_data", 64'(bus_data[31:0]), 64'hDEAD_BEEF);
    chk("t2_src", 64'(bus_src[2:0]), 64'd0);
    idle();

    // All five sources at once from rr_ptr=0
    do_reset();
    step(5'b11111, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
         {32'h44, 32'h33, 32'h22, 32'h11, 32'h00}, 1'b0, '0);
`ifndef CDB_BYPASS_EN
    idle();
`endif
    chk("t3_lanes01", 64'({bus_valid, bus_tag}), 64'({2'b11, 3'd1, 3'd0}));
    idle();
    chk("t3_lanes23", 64'({bus_valid, bus_tag}), 64'({2'b11, 3'd3, 3'd2}));
    idle();
    chk("t3_lane4", 64'({bus_valid, bus_tag[2:0]}), 64'({2'b01, 3'd4}));
    // rr_ptr back at 0: sources 0 and 1 win over source 4
    step(5'b10011, {3'd7, 3'd0, 3'd0, 3'd6, 3'd5},
         {32'h77, 32'h0, 32'h0, 32'h66, 32'h55}, 1'b0, '0);
`ifndef CDB_BYPASS_EN
    idle();
`endif
    chk("t3_rr0", 64'({bus_valid, bus_tag}), 64'({2'b11, 3'd6, 3'd5}));
    idle();
    idle();

    // Source 2 held valid while sources 0/1 compete every cycle
    for (int c = 0; c < 4; c++) begin
      step(5'b00111, {6'd0, 3'(c), 3'(c + 4), 3'(c)},
           {64'd0, 32'(32'h2000 + c), 32'(32'h1000 + c), 32'(32'h0000 + c)}, 1'b0, '0);
    end
    repeat (6) idle();

    // Flush of tag 5 while it is queued in FIFO 1; tag 5 pushed by source 3 during flush
    do_reset();
    step(5'b00010, {9'd0, 3'd5, 3'd0}, {96'd0, 32'h5555, 32'd0}, 1'b0, '0);
    step(5'b01010, {3'd0, 3'd5, 3'd0, 3'd6, 3'd0},
         {32'd0, 32'h3555, 32'd0, 32'h6666, 32'd0}, 1'b1, 8'b0010_0000);
`ifndef CDB_BYPASS_EN
    idle();
    chk("t5_tag6", 64'({bus_valid, bus_tag[2:0]}), 64'({2'b01, 3'd6}));
`endif
    repeat (3) idle();

    // Reset in the middle of a burst
    step(5'b00111, {6'd0, 3'd2, 3'd1, 3'd0}, {64'd0, 32'hA2, 32'hA1, 32'hA0}, 1'b0, '0);
    step(5'b00111, {6'd0, 3'd5, 3'd4, 3'd3}, {64'd0, 32'hB2, 32'hB1, 32'hB0}, 1'b0, '0);
    rst       = 1'b1;
    src_valid = '1;
    #1;
    chk("t6_bus_valid_async", 64'(bus_valid), 64'h0);
    chk("t6_ready_async", 64'(src_ready), 64'h1F);
    @(negedge clk);
    rst       = 1'b0;
    src_valid = '0;
    model_reset();
    repeat (3) idle();

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      rv = NS'($urandom);
      rt = (NS*TW)'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rf = ($urandom_range(0, 7) == 0);
      rm = 8'($urandom);
      step(rv, rt, rd, rf, rm);
    end
    repeat (6) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
